// File: rtl/mmio_tone_player.sv
// Memory-mapped square-wave note player: CPU stores queue note words in a small FIFO,
// which are played back-to-back on a registered 1-bit audio pin.
module mmio_tone_player #(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        stop,
  output logic        audioOut,
  output logic [31:0] status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } state_t;

  logic [29:0]   fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [17:0]   halfPeriod_q, halfPeriod_d;
  logic [11:0]   duration_q, duration_d;
  logic [17:0]   hpCnt_q, hpCnt_d;
  logic [11:0]   durCnt_q, durCnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          audio_q, audio_d;

  logic fifoEmpty, fifoFull, push, pop;
  logic [29:0] headWord;
  // The two control bits of the note word carry no meaning for this block.
  logic unusedCtrlBits;

  assign unusedCtrlBits = ^wr_data[31:30];

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CW'(FIFO_DEPTH));
  assign pop       = (state_q == IDLE) && !fifoEmpty && !stop;
  // A pop on the same edge frees a slot, so a push into a full FIFO still succeeds.
  assign push      = wr_en && !stop && (!fifoFull || pop);
  assign headWord  = fifoMem_q[rdPtr_q];

  always_ff @(posedge clock) begin
    if (push) fifoMem_q[wrPtr_q] <= wr_data[29:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
      halfPeriod_q <= '0;
      duration_q   <= '0;
      hpCnt_q      <= '0;
      durCnt_q     <= '0;
      presc_q      <= '0;
      audio_q      <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      halfPeriod_q <= halfPeriod_d;
      duration_q   <= duration_d;
      hpCnt_q      <= hpCnt_d;
      durCnt_q     <= durCnt_d;
      presc_q      <= presc_d;
      audio_q      <= audio_d;
    end
  end

  always_comb begin
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    state_d      = state_q;
    halfPeriod_d = halfPeriod_q;
    duration_d   = duration_q;
    hpCnt_d      = hpCnt_q;
    durCnt_d     = durCnt_q;
    presc_d      = presc_q;
    audio_d      = audio_q;

    if (stop) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (wr_en && !push) overflow_d = 1'b1;
    end

    if (stop) begin
      state_d = IDLE;
      audio_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          audio_d = 1'b0;
          if (pop) begin
            halfPeriod_d = headWord[17:0];
            duration_d   = headWord[29:18];
            state_d      = LOAD;
          end
        end
        LOAD: begin
          if (duration_q == '0) begin
            audio_d = 1'b0;
            state_d = IDLE;
          end else begin
            durCnt_d = duration_q;
            presc_d  = PRESC_RELOAD;
            hpCnt_d  = (halfPeriod_q == '0) ? '0 : halfPeriod_q - 18'd1;
            audio_d  = (halfPeriod_q != '0);
            state_d  = PLAY;
          end
        end
        PLAY: begin
          // Rests keep the half-period counter parked at 0 and the pin low.
          if (hpCnt_q == '0) begin
            hpCnt_d = (halfPeriod_q == '0) ? '0 : halfPeriod_q - 18'd1;
            audio_d = (halfPeriod_q != '0) && !audio_q;
          end else begin
            hpCnt_d = hpCnt_q - 18'd1;
          end
          if (presc_q == '0) begin
            presc_d = PRESC_RELOAD;
            if (durCnt_q == 12'd1) begin
              audio_d = 1'b0;
              state_d = IDLE;
            end else begin
              durCnt_d = durCnt_q - 12'd1;
            end
          end else begin
            presc_d = presc_q - 1'b1;
          end
        end
        default: begin
          audio_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign audioOut = audio_q;
  assign status   = {24'b0, 4'(count_q), overflow_q, fifoFull, fifoEmpty, state_q != IDLE};

endmodule

// File: tb/tb_mmio_tone_player.sv
// Self-checking bench for mmio_tone_player: directed scenarios plus randomized note
// sequences compared against a timeline model of when each note starts and ends.
module tb_mmio_tone_player;

  localparam int DEPTH = 4;
  localparam int TD    = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        stop = 1'b0;
  logic        audioOut;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  // Timeline model: each note is popped at mPop[i] (edge index relative to the first
  // write), plays from the next edge for dur*TD edges, and the next pop follows 2+dur*TD later.
  int mK;
  int mHp  [8];
  int mDur [8];
  int mPop [9];

  mmio_tone_player #(
    .FIFO_DEPTH(DEPTH),
    .TICK_DIV  (TD)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .stop    (stop),
    .audioOut(audioOut),
    .status  (status)
  );

  always #5 clock = ~clock;

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    wr_en = 1'b0;
    stop  = 1'b0;
    stepCycle();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] noteWord(input int hp, input int dur);
    return {2'($urandom_range(3)), 12'(dur), 18'(hp)};
  endfunction

  function automatic void buildModel();
    mPop[0] = 1;
    for (int i = 0; i < mK; i++) mPop[i+1] = mPop[i] + 2 + mDur[i] * TD;
  endfunction

  function automatic logic expAudio(input int t);
    logic r;
    r = 1'b0;
    for (int i = 0; i < mK; i++)
      if (mHp[i] != 0 && t >= mPop[i] + 1 && t < mPop[i] + 1 + mDur[i] * TD &&
          (((t - mPop[i] - 1) / mHp[i]) % 2) == 0)
        r = 1'b1;
    return r;
  endfunction

  function automatic logic expBusy(input int t);
    logic r;
    r = 1'b0;
    for (int i = 0; i < mK; i++)
      if (t >= mPop[i] && t < mPop[i] + 1 + mDur[i] * TD) r = 1'b1;
    return r;
  endfunction

  function automatic int expCount(input int t);
    int pushes, pops;
    pushes = (t + 1 < mK) ? t + 1 : mK;
    pops = 0;
    for (int i = 0; i < mK; i++) if (mPop[i] <= t) pops++;
    return pushes - pops;
  endfunction

  task automatic run_model(input string name);
    int c;
    logic [31:0] expSt;
    logic ea;
    buildModel();
    for (int t = 0; t <= mPop[mK] + 2; t++) begin
      if (t < mK) begin
        wr_en   = 1'b1;
        wr_data = noteWord(mHp[t], mDur[t]);
      end else begin
        wr_en = 1'b0;
      end
      stepCycle();
      c     = expCount(t);
      ea    = expAudio(t);
      expSt = {24'b0, 4'(c), 1'b0, c == DEPTH, c == 0, expBusy(t)};
      checks++;
      if (audioOut !== ea) begin
        errors++;
        $display("[TB] FAIL %s audio t=%0d got %b want %b", name, t, audioOut, ea);
      end
      checks++;
      if (status !== expSt) begin
        errors++;
        $display("[TB] FAIL %s status t=%0d got %h want %h", name, t, status, expSt);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_en   = (i == 0);
      wr_data = noteWord(3, 2);
      stepCycle();
      checks++;
      if (audioOut !== 1'b0 || status !== 32'h2) begin
        errors++;
        $display("[TB] FAIL reset cycle%0d audio=%b status=%h want 0/00000002", i, audioOut, status);
      end
    end
    reset = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checks++;
      if (audioOut !== 1'b0 || status !== 32'h2) begin
        errors++;
        $display("[TB] FAIL reset_nopush audio=%b status=%h want 0/00000002", audioOut, status);
      end
    end
  endtask

  task automatic test_single_tone();
    logic ea, eb;
    doReset();
    for (int t = 0; t <= 25; t++) begin
      wr_en   = (t == 0);
      wr_data = noteWord(3, 2);
      stepCycle();
      ea = (t >= 2 && t < 22) && (((t - 2) / 3) % 2 == 0);
      eb = (t >= 1 && t < 22);
      checks++;
      if (audioOut !== ea || status[0] !== eb) begin
        errors++;
        $display("[TB] FAIL single_tone t=%0d audio=%b busy=%b want %b/%b", t, audioOut, status[0], ea, eb);
      end
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    mK = 3;
    mHp[0] = 2; mDur[0] = 1;
    mHp[1] = 0; mDur[1] = 1;
    mHp[2] = 1; mDur[2] = 1;
    run_model("back_to_back");
  endtask

  task automatic test_overflow();
    int waited;
    doReset();
    for (int t = 0; t < 6; t++) begin
      wr_en   = 1'b1;
      wr_data = (t == 0) ? noteWord(5, 3) : noteWord(1, 0);
      stepCycle();
      if (t == 4) begin
        checks++;
        if (status !== 32'h45) begin
          errors++;
          $display("[TB] FAIL overflow_full status=%h want 00000045", status);
        end
      end
    end
    wr_en = 1'b0;
    checks++;
    if (status !== 32'h4D) begin
      errors++;
      $display("[TB] FAIL overflow_set status=%h want 0000004d", status);
    end
    waited = 0;
    while (status !== 32'h0A && waited < 100) begin
      stepCycle();
      waited++;
    end
    checks++;
    if (status !== 32'h0A) begin
      errors++;
      $display("[TB] FAIL overflow_sticky_drain status=%h want 0000000a", status);
    end
    stop = 1'b1;
    stepCycle();
    stop = 1'b0;
    checks++;
    if (status !== 32'h0A) begin
      errors++;
      $display("[TB] FAIL overflow_after_stop status=%h want 0000000a", status);
    end
  endtask

  task automatic test_push_pop();
    doReset();
    for (int t = 0; t <= 13; t++) begin
      wr_en   = (t <= 4) || (t == 13);
      wr_data = (t == 0) ? noteWord(1, 1) : noteWord(2, 0);
      stepCycle();
    end
    wr_en = 1'b0;
    checks++;
    if (status !== 32'h45) begin
      errors++;
      $display("[TB] FAIL push_pop_full status=%h want 00000045", status);
    end
  endtask

  task automatic test_zero_duration();
    logic [31:0] es;
    doReset();
    for (int t = 0; t <= 6; t++) begin
      wr_en   = (t == 0);
      wr_data = noteWord(3, 0);
      stepCycle();
      es = (t == 0) ? 32'h10 : (t == 1) ? 32'h03 : 32'h02;
      checks++;
      if (audioOut !== 1'b0 || status !== es) begin
        errors++;
        $display("[TB] FAIL zero_dur t=%0d audio=%b status=%h want 0/%h", t, audioOut, status, es);
      end
    end
  endtask

  task automatic test_stop();
    doReset();
    for (int t = 0; t <= 5; t++) begin
      wr_en   = (t <= 2);
      wr_data = (t == 0) ? noteWord(2, 3) : noteWord(1, 1);
      stepCycle();
    end
    checks++;
    if (status !== 32'h21 || audioOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_pre status=%h audio=%b want 00000021/0", status, audioOut);
    end
    stop    = 1'b1;
    wr_en   = 1'b1;
    wr_data = noteWord(2, 2);
    stepCycle();
    stop  = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (status !== 32'h02 || audioOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_flush status=%h audio=%b want 00000002/0", status, audioOut);
    end
    for (int t = 0; t < 5; t++) begin
      stepCycle();
      checks++;
      if (status !== 32'h02 || audioOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stop_quiet status=%h audio=%b want 00000002/0", status, audioOut);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      doReset();
      mK = $urandom_range(4, 1);
      for (int i = 0; i < mK; i++) begin
        mHp[i]  = $urandom_range(4, 0);
        mDur[i] = $urandom_range(2, 0);
      end
      run_model("random");
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_zero_duration();
    test_stop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
